// File: rtl/uart_tx_buffered.sv
// Buffered 8N1 UART transmitter: byte FIFO, then a serialiser whose bit period is latched per frame.
// Latency: start bit begins one edge after a byte lands in an empty FIFO. tx_ready drops when the FIFO is full.
// Even parity is inserted after the data bits when UART_TX_PARITY_EN is defined.
module uart_tx_buffered #(
    parameter int DATA_WIDTH = 8,
    parameter int DIV_WIDTH  = 32,
    parameter int FIFO_DEPTH = 16
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic [DIV_WIDTH-1:0]          uart_divide,
    input  logic [DATA_WIDTH-1:0]         tx_data,
    input  logic                          tx_valid,
    output logic                          tx_ready,
    output logic                          txd,
    output logic                          tx_busy,
    output logic [$clog2(FIFO_DEPTH):0]   tx_count,
    output logic                          frame_done
);

    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int CW = AW + 1;
    localparam int BW = $clog2(DATA_WIDTH + 1);

`ifdef UART_TX_PARITY_EN
    typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_t;
`else
    typedef enum logic [2:0] {IDLE, START, DATA, STOP} state_t;
`endif

    logic [DATA_WIDTH-1:0] mem_q [FIFO_DEPTH];
    logic [AW-1:0]         wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]         count_q, count_d;

    state_t                state_q, state_d;
    logic [DATA_WIDTH-1:0] shift_q, shift_d, shifted;
    logic [BW-1:0]         bit_q, bit_d;
    logic [DIV_WIDTH-1:0]  cnt_q, cnt_d, period_q, period_d, p_eff;
    logic                  txd_q, txd_d, frame_done_q, frame_done_d;
`ifdef UART_TX_PARITY_EN
    logic                  par_q, par_d;
`endif

    logic full, push, pop;

    assign full     = (count_q == CW'(FIFO_DEPTH));
    assign tx_ready = !full;
    assign push     = tx_valid && !full;
    assign p_eff    = (uart_divide < DIV_WIDTH'(2)) ? DIV_WIDTH'(2) : uart_divide;
    assign shifted  = shift_q >> 1;

    // Pointers and occupancy; a simultaneous push and pop leaves count unchanged.
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (push) wr_ptr_d = wr_ptr_q + AW'(1);
        if (pop)  rd_ptr_d = rd_ptr_q + AW'(1);
        if (push && !pop)      count_d = count_q + CW'(1);
        else if (pop && !push) count_d = count_q - CW'(1);
    end

    always_comb begin
        state_d      = state_q;
        shift_d      = shift_q;
        bit_d        = bit_q;
        cnt_d        = cnt_q;
        period_d     = period_q;
        txd_d        = txd_q;
        frame_done_d = 1'b0;
        pop          = 1'b0;
`ifdef UART_TX_PARITY_EN
        par_d        = par_q;
`endif
        case (state_q)
            IDLE: begin
                txd_d = 1'b1;
                pop   = (count_q != '0);
            end
            START: begin
                if (cnt_q == '0) begin
                    txd_d   = shift_q[0];
                    cnt_d   = period_q - DIV_WIDTH'(1);
                    state_d = DATA;
                end else begin
                    cnt_d = cnt_q - DIV_WIDTH'(1);
                end
            end
            DATA: begin
                if (cnt_q == '0) begin
                    cnt_d = period_q - DIV_WIDTH'(1);
                    if (bit_q == BW'(DATA_WIDTH - 1)) begin
`ifdef UART_TX_PARITY_EN
                        txd_d   = par_q;
                        state_d = PARITY;
`else
                        txd_d   = 1'b1;
                        state_d = STOP;
`endif
                    end else begin
                        shift_d = shifted;
                        txd_d   = shifted[0];
                        bit_d   = bit_q + BW'(1);
                    end
                end else begin
                    cnt_d = cnt_q - DIV_WIDTH'(1);
                end
            end
`ifdef UART_TX_PARITY_EN
            PARITY: begin
                if (cnt_q == '0) begin
                    txd_d   = 1'b1;
                    cnt_d   = period_q - DIV_WIDTH'(1);
                    state_d = STOP;
                end else begin
                    cnt_d = cnt_q - DIV_WIDTH'(1);
                end
            end
`endif
            STOP: begin
                txd_d = 1'b1;
                // Registered pulse lands in the last stop cycle (P >= 2, so cnt==1 always occurs).
                frame_done_d = (cnt_q == DIV_WIDTH'(1));
                if (cnt_q == '0) begin
                    state_d = IDLE;
                    pop     = (count_q != '0);
                end else begin
                    cnt_d = cnt_q - DIV_WIDTH'(1);
                end
            end
            default: state_d = IDLE;
        endcase

        // Popping from IDLE or the final stop cycle keeps back-to-back frames gapless.
        if (pop) begin
            shift_d  = mem_q[rd_ptr_q];
            period_d = p_eff;
            cnt_d    = p_eff - DIV_WIDTH'(1);
            bit_d    = '0;
            txd_d    = 1'b0;
            state_d  = START;
`ifdef UART_TX_PARITY_EN
            par_d    = ^mem_q[rd_ptr_q];
`endif
        end
    end

    always_ff @(posedge clk) begin
        if (push) mem_q[wr_ptr_q] <= tx_data;
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            wr_ptr_q     <= '0;
            rd_ptr_q     <= '0;
            count_q      <= '0;
            state_q      <= IDLE;
            shift_q      <= '0;
            bit_q        <= '0;
            cnt_q        <= '0;
            period_q     <= DIV_WIDTH'(2);
            txd_q        <= 1'b1;
            frame_done_q <= 1'b0;
`ifdef UART_TX_PARITY_EN
            par_q        <= 1'b0;
`endif
        end else begin
            wr_ptr_q     <= wr_ptr_d;
            rd_ptr_q     <= rd_ptr_d;
            count_q      <= count_d;
            state_q      <= state_d;
            shift_q      <= shift_d;
            bit_q        <= bit_d;
            cnt_q        <= cnt_d;
            period_q     <= period_d;
            txd_q        <= txd_d;
            frame_done_q <= frame_done_d;
`ifdef UART_TX_PARITY_EN
            par_q        <= par_d;
`endif
        end
    end

    assign txd        = txd_q;
    assign frame_done = frame_done_q;
    assign tx_count   = count_q;
    assign tx_busy    = (state_q != IDLE) || (count_q != '0);

endmodule

// File: tb/tb_uart_tx_buffered.sv
// Directed bench for uart_tx_buffered: a line receiver decodes txd against a byte/period scoreboard.
module tb_uart_tx_buffered;

`ifdef UART_TX_PARITY_EN
    localparam int NB = 11;
`else
    localparam int NB = 10;
`endif

    logic        clk;
    logic        rst;
    logic [31:0] uart_divide;
    logic [7:0]  tx_data;
    logic        tx_valid;
    logic        tx_ready;
    logic        txd;
    logic        tx_busy;
    logic [4:0]  tx_count;
    logic        frame_done;

    uart_tx_buffered #(.DATA_WIDTH(8), .DIV_WIDTH(32), .FIFO_DEPTH(16)) dut (
        .clk(clk), .rst(rst), .uart_divide(uart_divide), .tx_data(tx_data),
        .tx_valid(tx_valid), .tx_ready(tx_ready), .txd(txd), .tx_busy(tx_busy),
        .tx_count(tx_count), .frame_done(frame_done)
    );

    typedef struct {
        logic [7:0] b;
        int         p;
    } sb_t;

    sb_t sb_q[$];
    int  checks = 0;
    int  failures = 0;
    int  cyc = 0;
    bit  b2b_chk = 0;

    initial begin
        clk = 0;
        forever #5 clk = ~clk;
    end

    always @(posedge clk) cyc <= cyc + 1;

    initial begin
        #400000;
        $display("FAIL global_timeout: simulation exceeded time limit");
        $fatal(1, "timeout");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    function automatic logic exp_bit(input logic [7:0] b, input int k);
        if (k == 0) return 1'b0;
        if (k <= 8) return b[k-1];
`ifdef UART_TX_PARITY_EN
        if (k == 9) return ^b;
`endif
        return 1'b1;
    endfunction

    // Line receiver: samples each bit mid-period using the period recorded for that frame.
    bit         rx_active = 0;
    int         rx_off;
    int         last_done_cyc = 0;
    sb_t        rx_exp;
    logic [7:0] rx_byte;

    always @(negedge clk) begin
        if (rst !== 1'b1) begin
            rx_active = 0;
        end else if (!rx_active) begin
            if (txd === 1'b0) begin
                check("rx_frame_expected", 32'(sb_q.size() != 0), 32'd1);
                if (sb_q.size() != 0) begin
                    rx_exp    = sb_q.pop_front();
                    rx_active = 1;
                    rx_off    = 0;
                    rx_byte   = 8'h00;
                    if (b2b_chk) check("rx_gap_cycles", 32'(cyc - last_done_cyc), 32'd1);
                end
            end
        end else begin
            rx_off++;
        end
        if (rx_active) begin
            if (rx_off % rx_exp.p == rx_exp.p / 2) begin
                int k;
                k = rx_off / rx_exp.p;
                if (k >= 1 && k <= 8) rx_byte[k-1] = txd;
                else check("rx_framing_bit", 32'(txd), 32'(exp_bit(rx_exp.b, k)));
            end
            check("rx_frame_done", 32'(frame_done), 32'(rx_off == NB * rx_exp.p - 1));
            if (rx_off == NB * rx_exp.p - 1) begin
                check("rx_byte", 32'(rx_byte), 32'(rx_exp.b));
                last_done_cyc = cyc;
                rx_active = 0;
            end
        end
    end

    task automatic push_byte(input logic [7:0] b, input int p);
        int g = 0;
        tx_data  = b;
        tx_valid = 1'b1;
        while (!tx_ready && g < 2000) begin
            @(posedge clk); #1;
            g++;
        end
        check("push_wait_bounded", 32'(g < 2000), 32'd1);
        @(posedge clk); #1;
        sb_q.push_back('{b: b, p: p});
        tx_valid = 1'b0;
    endtask

    task automatic wait_drain();
        int g = 0;
        while ((tx_busy || sb_q.size() != 0 || rx_active) && g < 5000) begin
            @(posedge clk); #1;
            g++;
        end
        check("drain_bounded", 32'(g < 5000), 32'd1);
        check("drain_count", 32'(tx_count), 32'd0);
    endtask

    initial begin
        string burst;
        rst = 1'b0; tx_valid = 1'b0; tx_data = 8'h00; uart_divide = 32'd4;

        // Reset then idle
        repeat (3) @(posedge clk);
        #1 rst = 1'b1;
        for (int i = 0; i < 100; i++) begin
            @(posedge clk); #1;
            check("idle_txd", 32'(txd), 32'd1);
            check("idle_ready", 32'(tx_ready), 32'd1);
            check("idle_count", 32'(tx_count), 32'd0);
            check("idle_busy", 32'(tx_busy), 32'd0);
            check("idle_frame_done", 32'(frame_done), 32'd0);
        end

        // Single byte with cycle-exact waveform, P=4
        uart_divide = 32'd4;
        push_byte(8'h61, 4);
        check("single_pre_start_txd", 32'(txd), 32'd1);
        check("single_busy", 32'(tx_busy), 32'd1);
        for (int c = 1; c <= NB * 4; c++) begin
            @(posedge clk); #1;
            check("single_txd", 32'(txd), 32'(exp_bit(8'h61, (c - 1) / 4)));
            check("single_frame_done", 32'(frame_done), 32'(c == NB * 4));
        end
        @(posedge clk); #1;
        check("single_after_txd", 32'(txd), 32'd1);
        check("single_after_busy", 32'(tx_busy), 32'd0);
        check("single_after_fd", 32'(frame_done), 32'd0);

        // Burst of 17 bytes fills the FIFO, then a held push across a pop
        uart_divide = 32'd2;
        burst = "abcdefghijklmnopq";
        for (int i = 0; i < 17; i++) push_byte(burst[i], 2);
        check("burst_count_full", 32'(tx_count), 32'd16);
        check("burst_ready_low", 32'(tx_ready), 32'd0);
        b2b_chk = 1;
        push_byte(8'h72, 2);
        check("full_pop_push_count", 32'(tx_count), 32'd16);
        wait_drain();
        b2b_chk = 0;

        // Small divider clamps to P=2
        uart_divide = 32'd0;
        push_byte(8'h3C, 2);
        wait_drain();
        uart_divide = 32'd1;
        push_byte(8'hC3, 2);
        wait_drain();

        // Divider change mid-frame applies only to the next frame
        uart_divide = 32'd4;
        push_byte(8'h5A, 4);
        repeat (15) @(posedge clk);
        #1 uart_divide = 32'd8;
        push_byte(8'hA5, 8);
        wait_drain();

        // Reset during data bit 3 with bytes queued
        uart_divide = 32'd4;
        push_byte(8'h11, 4);
        push_byte(8'h22, 4);
        push_byte(8'h33, 4);
        push_byte(8'h44, 4);
        push_byte(8'h55, 4);
        repeat (14) @(posedge clk);
        #1 rst = 1'b0;
        @(posedge clk); #1;
        check("rst_mid_txd", 32'(txd), 32'd1);
        check("rst_mid_count", 32'(tx_count), 32'd0);
        check("rst_mid_busy", 32'(tx_busy), 32'd0);
        check("rst_mid_ready", 32'(tx_ready), 32'd1);
        sb_q.delete();
        rst = 1'b1;
        for (int i = 0; i < 60; i++) begin
            @(posedge clk); #1;
            check("rst_flushed_txd", 32'(txd), 32'd1);
        end
        push_byte(8'h42, 4);
        wait_drain();

        // 0x07 has odd weight: parity bit 1 when parity is built in
        push_byte(8'h07, 4);
        wait_drain();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/uart_tx_buffered.md
Name: uart_tx_buffered

Overview:
- Device-side UART transmitter with an internal byte FIFO and a programmable bit-period divider.
- Accepts bytes from the core over a valid/ready handshake and serialises them onto txd as 8N1 frames (optional parity), LSB first.
- Sits between the JPU I/O logic and the board uart_rxd_out pin.
- Line format matches the bench receiver and uart_rx, so core output can be checked byte-for-byte in simulation.

Parameters:
- DATA_WIDTH, 8, bits per frame payload
- DIV_WIDTH, 32, width of uart_divide
- FIFO_DEPTH, 16, TX FIFO entries; power of 2, >= 2

Ports:
- clk  input  1  clock
- rst  input  1  synchronous, active-low reset
- uart_divide  input  DIV_WIDTH  clocks per bit; sampled at frame start
- tx_data  input  DATA_WIDTH  byte to enqueue
- tx_valid  input  1  enqueue request
- tx_ready  output  1  FIFO not full; a byte is accepted when tx_valid && tx_ready at a clk edge
- txd  output  1  serial line, idle high
- tx_busy  output  1  frame in progress or FIFO non-empty
- tx_count  output  $clog2(FIFO_DEPTH)+1  FIFO occupancy
- frame_done  output  1  one-cycle pulse in the final cycle of each stop bit

Behaviour:
- Reset (sampled when rst==0 at a clk edge):
  - txd=1, tx_count=0, tx_busy=0, frame_done=0, FSM=IDLE.
  - FIFO pointers cleared; contents are don't-care.
  - tx_ready=1 from the first cycle after reset.
- Reset mid-frame: txd returns high at that edge, the frame is aborted, and the FIFO is flushed. No partial frame resumes.
- tx_ready = !full, combinational from registered occupancy.
- A push while full is ignored, with no state change. Push and pop in the same cycle are both honoured and tx_count is unchanged.
- Effective bit period P = max(uart_divide, 2). P is latched into a register on the pop edge and held for the whole frame. A change to uart_divide mid-frame affects only the next frame.
- FSM states: IDLE, START, DATA, PARITY (present only with the optional feature), STOP.
  - IDLE: if tx_count != 0, pop the head entry into the shift register, load P, clear the bit counter, set txd=0 at this edge, go to START. Otherwise txd=1.
  - START: hold txd=0 for P cycles, then drive txd=shift[0] and go to DATA.
  - DATA: each bit lasts P cycles. After each bit, shift right and increment the bit index. After bit DATA_WIDTH-1, go to STOP (or PARITY).
  - STOP: txd=1 for P cycles. frame_done=1 in the last cycle. Next state is IDLE, which can pop immediately, so there are zero idle cycles between back-to-back frames.
- Latency: a byte accepted at edge N into an empty FIFO with the FSM in IDLE gives a start bit beginning at edge N+1. The frame occupies exactly (2+DATA_WIDTH)*P cycles (plus P with parity).
- Bit timing counter counts P-1 down to 0 and must not wrap for any P up to 2^DIV_WIDTH-1.
- tx_busy = (FSM != IDLE) || (tx_count != 0).
- FIFO pointers wrap modulo FIFO_DEPTH. tx_count saturates at FIFO_DEPTH, which is full.
- All outputs are registered except tx_ready and tx_busy.

Optional Feature:
- Macro: UART_TX_PARITY_EN
- Defined:
  - PARITY state inserted after DATA, driving txd = XOR of the data bits (even parity) for P cycles.
  - Frame length becomes (3+DATA_WIDTH)*P.
- Undefined: the PARITY state and its logic are absent; frames are 8N1.

Test Plan:
- Reset then idle: rst=0 for 3 cycles, then 1 -> txd=1, tx_ready=1, tx_count=0, tx_busy=0 for 100 cycles.
- Single byte: uart_divide=4, push 0x61 ('a') -> txd low at N+1 for 4 cycles, then bits 1,0,0,0,0,1,1,0 each 4 cycles, stop high 4 cycles. frame_done pulses at cycle N+40. The bench uart_rx reports 0x61 with no error.
- Burst/full: uart_divide=2, push 17 bytes "abcdefghijklmnopq" on consecutive cycles -> after the first pop the FIFO holds the remaining 16 bytes and tx_ready=0 is observed. Frames are back-to-back with no gaps, and all accepted bytes arrive in order.
- Push while full plus simultaneous pop: hold tx_valid=1 with a full FIFO at the edge of a pop -> exactly one byte is accepted, tx_count stays at 16, and there is no duplicate or dropped byte.
- Divider change and small value: uart_divide=0 -> P=2 (frame of 20 cycles). Change uart_divide from 4 to 8 mid-frame -> the current frame keeps P=4 and the next frame uses P=8.
- Reset mid-frame: assert rst during DATA bit 3 with 5 bytes queued -> txd=1 at the reset edge and tx_count=0. No further frames are transmitted, and the next pushed byte (0x42) transmits cleanly. With UART_TX_PARITY_EN defined, a 0x07 frame carries parity bit 1.
